switch_box_param: RTL and testbench



---
 rtl/switch_box_param.sv | 111 +++++++++++
 tb/tb_switch_box_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_box_param.sv
// Parametrised routing switch box: four sides of NUM_TRACKS tracks plus the PE output are
// routed onto every output track by a 3-bit select per output. Routing selects are held in
// a double-buffered config store: writes land in a shadow set, a commit copies it atomically.
module switch_box_param #(
  parameter int unsigned NUM_TRACKS = 8,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned REG_OUT    = 1,
  parameter int unsigned CFG_ADDR_W = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_TRACKS*WIDTH-1:0] in_wire,
  input  logic [WIDTH-1:0]              pe_output,
  output logic [4*NUM_TRACKS*WIDTH-1:0] out_wire,
  input  logic                          config_en,
  input  logic [CFG_ADDR_W-1:0]         config_addr,
  input  logic [31:0]                   config_data,
  input  logic                          config_commit,
  output logic [31:0]                   config_rdata,
  output logic                          config_active
);

  localparam int unsigned NumFields = 4 * NUM_TRACKS;
  localparam int unsigned NumWords  = (NumFields + 9) / 10;
  localparam int unsigned BusW      = 4 * NUM_TRACKS * WIDTH;

  logic [31:0]            shadow_q [NumWords];
  logic [31:0]            shadow_d [NumWords];
  // Active set keeps only the select fields; reserved bits never affect routing.
  logic [3*NumFields-1:0] active_q, active_d;
  logic                   cfg_active_q, cfg_active_d;
  logic [BusW-1:0]        out_d;

  // Shadow write; out-of-range addresses never match a word and are dropped.
  always_comb begin
    for (int unsigned w = 0; w < NumWords; w++) begin
      shadow_d[w] = shadow_q[w];
      if (config_en && (32'(config_addr) == w)) shadow_d[w] = config_data;
    end
  end

  // Commit copies the pre-write shadow, so a same-edge write waits for the next commit.
  always_comb begin
    active_d     = active_q;
    cfg_active_d = cfg_active_q;
    if (config_commit) begin
      cfg_active_d = 1'b1;
      for (int unsigned i = 0; i < NumFields; i++) begin
        active_d[3*i +: 3] = shadow_q[i/10][3*(i%10) +: 3];
      end
    end
  end

  // Config state; reset wins over write and commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q     <= '{default: '0};
      active_q     <= '0;
      cfg_active_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      cfg_active_q <= cfg_active_d;
    end
  end

  // Readback of the shadow word; out-of-range addresses read as zero.
  always_comb begin
    config_rdata = '0;
    for (int unsigned w = 0; w < NumWords; w++) begin
      if (32'(config_addr) == w) config_rdata = shadow_q[w];
    end
  end

  assign config_active = cfg_active_q;

  // Per-output mux; select k in 1..3 takes side (s+k)%4, so a side never feeds itself.
  always_comb begin
    logic [2:0] sel;
    sel   = '0;
    out_d = '0;
    for (int unsigned s = 0; s < 4; s++) begin
      for (int unsigned t = 0; t < NUM_TRACKS; t++) begin
        sel = active_q[3*(s*NUM_TRACKS+t) +: 3];
        case (sel)
          3'd1: out_d[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] =
                  in_wire[(((s+1)%4)*NUM_TRACKS+t)*WIDTH +: WIDTH];
          3'd2: out_d[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] =
                  in_wire[(((s+2)%4)*NUM_TRACKS+t)*WIDTH +: WIDTH];
          3'd3: out_d[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] =
                  in_wire[(((s+3)%4)*NUM_TRACKS+t)*WIDTH +: WIDTH];
          3'd4: out_d[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] = pe_output;
          default: out_d[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] = '0;
        endcase
      end
    end
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [BusW-1:0] out_q;
    // Output retiming register.
    always_ff @(posedge clk) begin
      if (reset) out_q <= '0;
      else       out_q <= out_d;
    end
    assign out_wire = out_q;
  end else begin : g_comb_out
    assign out_wire = out_d;
  end

endmodule

// File: tb/tb_switch_box_param.sv
// Directed bench for switch_box_param at default parameters (8 tracks x 16 bits, REG_OUT=1).
module tb_switch_box_param;

  localparam int NT   = 8;
  localparam int W    = 16;
  localparam int BUSW = 4 * NT * W;

  logic            clk = 1'b0;
  logic            reset;
  logic [BUSW-1:0] in_wire;
  logic [W-1:0]    pe_output;
  logic [BUSW-1:0] out_wire;
  logic            config_en;
  logic [3:0]      config_addr;
  logic [31:0]     config_data;
  logic            config_commit;
  logic [31:0]     config_rdata;
  logic            config_active;

  int checks = 0;
  int errors = 0;

  switch_box_param #(
    .NUM_TRACKS(NT),
    .WIDTH     (W),
    .REG_OUT   (1),
    .CFG_ADDR_W(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_wire      (in_wire),
    .pe_output    (pe_output),
    .out_wire     (out_wire),
    .config_en    (config_en),
    .config_addr  (config_addr),
    .config_data  (config_data),
    .config_commit(config_commit),
    .config_rdata (config_rdata),
    .config_active(config_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        commit;
    logic [31:0] exp_rdata;
    logic        exp_active;
  } cfg_vec_t;

  cfg_vec_t vecs [6];

  function automatic logic [BUSW-1:0] trk(input int idx, input logic [W-1:0] v);
    logic [BUSW-1:0] r;
    r = '0;
    r[idx*W +: W] = v;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [BUSW-1:0] exp);
    checks++;
    if (out_wire !== exp) begin
      errors++;
      $display("FAIL %s out_wire got %h want %h", name, out_wire, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    reset         = 1'b1;
    in_wire       = '1;
    pe_output     = 16'hA5A5;
    config_en     = 1'b0;
    config_addr   = '0;
    config_data   = '0;
    config_commit = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state: everything zero even with all inputs driven high.
    chk_out("reset_out", '0);
    chk32("reset_active", 32'(config_active), 32'd0);
    for (int a = 0; a < 16; a++) begin
      config_addr = 4'(a);
      #1;
      chk32($sformatf("reset_rdata_%0d", a), config_rdata, 32'd0);
    end
    step();
    chk_out("idle_out", '0);

    // Route side1 track0 onto side0 track0; 2 edges from commit to output.
    in_wire     = trk(8, 16'h1234);
    config_en   = 1'b1;
    config_addr = 4'd0;
    config_data = 32'h0000_0001;
    step();
    config_en     = 1'b0;
    config_commit = 1'b1;
    step();
    config_commit = 1'b0;
    chk_out("commit_edge_out", '0);
    chk32("commit_active", 32'(config_active), 32'd1);
    step();
    chk_out("route_side1", trk(0, 16'h1234));
    in_wire = trk(8, 16'hBEEF);
    #1;
    chk_out("data_hold", trk(0, 16'h1234));
    step();
    chk_out("data_latency", trk(0, 16'hBEEF));

    // Field 31 -> PE output; shadow only until commit.
    config_en   = 1'b1;
    config_addr = 4'd3;
    config_data = 32'h0000_0020;
    step();
    config_en = 1'b0;
    chk32("rdata_w3", config_rdata, 32'h0000_0020);
    step();
    chk_out("no_commit_out", trk(0, 16'hBEEF));
    config_commit = 1'b1;
    step();
    config_commit = 1'b0;
    step();
    chk_out("pe_route", trk(0, 16'hBEEF) | trk(31, 16'hA5A5));
    pe_output = 16'h5A5A;
    step();
    chk_out("pe_follow", trk(0, 16'hBEEF) | trk(31, 16'h5A5A));

    // Write and commit on the same edge: active takes the old word0.
    in_wire       = trk(8, 16'hBEEF) | trk(16, 16'h7777);
    config_en     = 1'b1;
    config_addr   = 4'd0;
    config_data   = 32'h0000_0002;
    config_commit = 1'b1;
    step();
    config_en     = 1'b0;
    config_commit = 1'b0;
    step();
    chk_out("same_edge_old", trk(0, 16'hBEEF) | trk(31, 16'h5A5A));
    config_commit = 1'b1;
    step();
    config_commit = 1'b0;
    step();
    chk_out("next_commit_side2", trk(0, 16'h7777) | trk(31, 16'h5A5A));

    // Table: out-of-range writes, reserved bits, commits; routing must not move.
    vecs[0] = '{en: 1'b1, addr: 4'd5,  data: 32'hDEAD_BEEF, commit: 1'b0,
                exp_rdata: 32'h0,         exp_active: 1'b1};
    vecs[1] = '{en: 1'b1, addr: 4'd15, data: 32'hFFFF_FFFF, commit: 1'b0,
                exp_rdata: 32'h0,         exp_active: 1'b1};
    vecs[2] = '{en: 1'b0, addr: 4'd0,  data: 32'h0,         commit: 1'b1,
                exp_rdata: 32'h2,         exp_active: 1'b1};
    vecs[3] = '{en: 1'b1, addr: 4'd1,  data: 32'hC000_0000, commit: 1'b0,
                exp_rdata: 32'hC000_0000, exp_active: 1'b1};
    vecs[4] = '{en: 1'b0, addr: 4'd2,  data: 32'h0,         commit: 1'b1,
                exp_rdata: 32'h0,         exp_active: 1'b1};
    vecs[5] = '{en: 1'b0, addr: 4'd3,  data: 32'h0,         commit: 1'b0,
                exp_rdata: 32'h20,        exp_active: 1'b1};
    for (int v = 0; v < 6; v++) begin
      config_en     = vecs[v].en;
      config_addr   = vecs[v].addr;
      config_data   = vecs[v].data;
      config_commit = vecs[v].commit;
      step();
      config_en     = 1'b0;
      config_commit = 1'b0;
      chk32($sformatf("vec%0d_rdata", v), config_rdata, vecs[v].exp_rdata);
      chk32($sformatf("vec%0d_active", v), 32'(config_active), 32'(vecs[v].exp_active));
    end
    step();
    chk_out("table_route_kept", trk(0, 16'h7777) | trk(31, 16'h5A5A));

    // Reset mid-load (with a write on the reset edge) discards the shadow.
    config_en   = 1'b1;
    config_data = 32'h2492_4924;
    for (int a = 0; a < 3; a++) begin
      config_addr = 4'(a);
      step();
    end
    config_addr = 4'd3;
    reset       = 1'b1;
    step();
    reset     = 1'b0;
    config_en = 1'b0;
    chk32("mid_reset_active", 32'(config_active), 32'd0);
    chk_out("mid_reset_out", '0);
    config_commit = 1'b1;
    step();
    config_commit = 1'b0;
    chk32("post_reset_commit_active", 32'(config_active), 32'd1);
    step();
    chk_out("post_reset_commit_out", '0);
    for (int a = 0; a < 4; a++) begin
      config_addr = 4'(a);
      #1;
      chk32($sformatf("post_reset_rdata_%0d", a), config_rdata, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
